// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared constants for the PWM ramp controller: FSM state encodings and a
// helper that sizes counters which must hold at least one bit.
// No ports; imported by the top module.
package pwm_ramp_ctrl_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RAMP = 1'b1;

   // Width needed to count 0..n-1. A counter for n=1 still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_core.sv
// Purpose: free-running PWM phase counter plus registered duty compare.
// Latency: out reflects (phase < duty) one cycle after that phase; wrap is combinational.
// Backpressure: none, runs every cycle; duty is sampled continuously.
//
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   duty_i    - currently applied duty (held stable by the caller within a period)
//   wrap_o    - high while phase is on the last cycle of the period
//   out_o     - registered PWM output
module pwm_ramp_ctrl_core #(
   parameter int period = 8,
   parameter int W      = $clog2(period)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] duty_i,
   output logic         wrap_o,
   output logic         out_o
);

   localparam logic [W-1:0] PHASE_LAST = W'(period - 1);

   logic [W-1:0] phase_q;
   logic [W-1:0] phase_d;
   logic         out_q;
   logic         out_d;

   assign wrap_o  = (phase_q == PHASE_LAST);
   assign phase_d = wrap_o ? '0 : phase_q + W'(1);
   // Duty 0 never matches, so the pin stays low for the whole period.
   assign out_d   = (phase_q < duty_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         out_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         out_q   <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Purpose: slew-limited PWM duty controller; steps duty by 1 LSB every step_per periods toward a target.
// Latency: transfer visible on busy/tgt_ready next cycle; each step lands on a wrap edge, seen on duty at phase 0.
// Backpressure: tgt_ready low for the whole ramp; the source must hold tgt_valid until it returns.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   tgt, tgt_valid      - requested target duty and its offer strobe
//   tgt_ready           - registered; high when the controller is idle
//   duty                - duty currently applied to the compare stage
//   busy                - a ramp is in progress
//   wrap                - one-cycle pulse on the last cycle of each PWM period
//   out                 - PWM pin
module pwm_ramp_ctrl
   import pwm_ramp_ctrl_pkg::*;
#(
   parameter int  period   = 8,
   parameter int  step_per = 1,
   localparam int W        = $clog2(period)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] tgt,
   input  logic         tgt_valid,
   output logic         tgt_ready,
   output logic [W-1:0] duty,
   output logic         busy,
   output logic         wrap,
   output logic         out
);

   localparam int            SW       = cnt_width(step_per);
   localparam logic [SW-1:0] CNT_LAST = SW'(step_per - 1);

   logic [0:0]    state_q, state_d;
   logic [W-1:0]  tgt_q,   tgt_d;
   logic [W-1:0]  duty_q,  duty_d;
   logic [SW-1:0] cnt_q,   cnt_d;
   logic          rdy_q,   rdy_d;

   logic          xfer;
   logic          wrap_w;
   logic [W-1:0]  duty_step;

   assign xfer = tgt_valid & rdy_q;

   // One LSB toward the target. Only used while ramping, when the two
   // differ, so neither direction can leave the 0..period-1 range.
   assign duty_step = (tgt_q > duty_q) ? duty_q + W'(1) : duty_q - W'(1);

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      duty_d  = duty_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // A wrap in the transfer cycle is deliberately not counted:
            // counting starts from the cleared value on the next wrap.
            if (xfer) begin
               tgt_d = tgt;
               cnt_d = '0;
               if (tgt != duty_q) begin
                  state_d = ST_RAMP;
               end
            end
         end
         ST_RAMP: begin
            if (wrap_w) begin
               if (cnt_q == CNT_LAST) begin
                  // Duty updates on the wrap edge, so the new value applies
                  // from phase 0 and no period is cut short.
                  cnt_d  = '0;
                  duty_d = duty_step;
                  if (duty_step == tgt_q) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + SW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered ready follows the next state, so it drops right after a
   // transfer and rises the cycle after the final step.
   assign rdy_d = (state_d == ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
         duty_q  <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
      end
   end

   pwm_ramp_ctrl_core #(
      .period (period),
      .W      (W)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .duty_i (duty_q),
      .wrap_o (wrap_w),
      .out_o  (out)
   );

   assign tgt_ready = rdy_q;
   assign duty      = duty_q;
   assign busy      = (state_q == ST_RAMP);
   assign wrap      = wrap_w;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: channel 0 uses step_per=1, channel 1 step_per=2,
// both with period 8. Expected per-period records and accepted targets are
// queued by the stimulus; the monitor checks them as the DUTs produce them.
module tb_pwm_ramp_ctrl;

   localparam int PER = 8;
   localparam int W   = 3;

   typedef struct packed {
      logic         ch;
      logic [3:0]   hi;
      logic [W-1:0] duty;
      logic         busy;
      logic         rdy;
   } rec_t;

   typedef struct packed {
      logic         ch;
      logic [W-1:0] tgt;
   } acc_t;

   logic                clk;
   logic                rst;
   logic [1:0][W-1:0]   tgt;
   logic [1:0]          tgt_valid;
   logic [1:0]          tgt_ready;
   logic [1:0][W-1:0]   duty;
   logic [1:0]          busy;
   logic [1:0]          wrap;
   logic [1:0]          pwm;

   rec_t win_q[$];
   acc_t acc_q[$];
   int   checks;
   int   errors;
   bit   done;

   logic [W-1:0] hold_v [4];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pwm_ramp_ctrl #(
         .period   (PER),
         .step_per (g + 1)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .tgt       (tgt[g]),
         .tgt_valid (tgt_valid[g]),
         .tgt_ready (tgt_ready[g]),
         .duty      (duty[g]),
         .busy      (busy[g]),
         .wrap      (wrap[g]),
         .out       (pwm[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rec(input int ch, input int hi, input int d, input int b, input int r);
      rec_t e;
      e.ch   = 1'(ch);
      e.hi   = 4'(hi);
      e.duty = W'(d);
      e.busy = 1'(b);
      e.rdy  = 1'(r);
      win_q.push_back(e);
   endtask

   task automatic offer(input int ch, input int v);
      acc_t a;
      a.ch  = 1'(ch);
      a.tgt = W'(v);
      acc_q.push_back(a);
      tgt[ch]       = W'(v);
      tgt_valid[ch] = 1'b1;
   endtask

   // Returns one cycle after the edge on which the offer was taken.
   task automatic wait_ready(input int ch);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (tgt_ready[ch] && tgt_valid[ch]) break;
      end
      tick();
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (win_q.size() == 0) break;
      end
      tick();
   endtask

   task automatic wait_idle(input int ch);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy[ch]) break;
      end
      tick();
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      rst       = 1'b0;
      tgt       = '0;
      tgt_valid = '0;
      done      = 1'b0;
      hold_v[0] = 3'd2;
      hold_v[1] = 3'd4;
      hold_v[2] = 3'd1;
      hold_v[3] = 3'd5;
      #1 rst = 1'b1;
      repeat (3) tick();

      // Ramp 0 -> 3 one step per period; target offered at release.
      rst = 1'b0;
      offer(0, 3);
      push_rec(0, 0, 1, 1, 0);
      push_rec(0, 1, 2, 1, 0);
      push_rec(0, 2, 3, 0, 1);
      push_rec(0, 3, 3, 0, 1);
      wait_ready(0);
      tgt_valid[0] = 1'b0;
      wait_drain();

      // Reset in the middle of a ramp to 5.
      offer(0, 5);
      wait_ready(0);
      tgt_valid[0] = 1'b0;
      repeat (12) tick();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Ramp 0 -> 6 while the source keeps offering other values; the
      // final held value equals the reached duty and is taken without a ramp.
      offer(0, 6);
      for (int k = 1; k <= 5; k++) push_rec(0, k - 1, k, 1, 0);
      push_rec(0, 5, 6, 0, 1);
      push_rec(0, 6, 6, 0, 1);
      push_rec(0, 6, 6, 0, 1);
      wait_ready(0);
      for (int i = 0; i < 4; i++) begin
         tgt[0] = hold_v[i];
         repeat (9) tick();
      end
      offer(0, 6);
      wait_ready(0);
      tgt_valid[0] = 1'b0;
      wait_drain();

      // step_per=2 channel: ramp up to 3, then back down to 0.
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      offer(1, 3);
      push_rec(1, 0, 0, 1, 0);
      push_rec(1, 0, 1, 1, 0);
      push_rec(1, 1, 1, 1, 0);
      push_rec(1, 1, 2, 1, 0);
      push_rec(1, 2, 2, 1, 0);
      push_rec(1, 2, 3, 0, 1);
      wait_ready(1);
      tgt_valid[1] = 1'b0;
      wait_drain();
      offer(1, 0);
      push_rec(1, 3, 3, 1, 0);
      push_rec(1, 3, 2, 1, 0);
      push_rec(1, 2, 2, 1, 0);
      push_rec(1, 2, 1, 1, 0);
      push_rec(1, 1, 1, 1, 0);
      push_rec(1, 1, 0, 0, 1);
      push_rec(1, 0, 0, 0, 1);
      wait_ready(1);
      tgt_valid[1] = 1'b0;
      wait_drain();

      // Maximum duty: seven high cycles, one low cycle per period.
      offer(0, 7);
      wait_ready(0);
      tgt_valid[0] = 1'b0;
      wait_idle(0);
      push_rec(0, 7, 7, 0, 1);
      push_rec(0, 7, 7, 0, 1);
      wait_drain();

      done = 1'b1;
   end

   // ------------------------------------------------------------------
   // Monitor / scoreboard (sole owner of the counters)
   // ------------------------------------------------------------------
   initial begin
      bit [1:0] prev_wrap;
      bit [1:0] gap_vld;
      int       hi  [2];
      int       gap [2];
      int       rel_cnt;
      int       h;
      rec_t     r;
      acc_t     a;

      checks    = 0;
      errors    = 0;
      prev_wrap = '0;
      gap_vld   = '0;
      rel_cnt   = 0;
      for (int c = 0; c < 2; c++) begin
         hi[c]  = 0;
         gap[c] = 0;
      end

      forever begin
         @(negedge clk);
         if (rst) begin
            for (int c = 0; c < 2; c++) begin
               checks++;
               if ({pwm[c], duty[c], busy[c], tgt_ready[c], wrap[c]} !== '0) begin
                  errors++;
                  $display("FAIL reset_state ch%0d got out=%b duty=%0d busy=%b rdy=%b wrap=%b want all 0",
                           c, pwm[c], duty[c], busy[c], tgt_ready[c], wrap[c]);
               end
               hi[c]  = 0;
               gap[c] = 0;
            end
            prev_wrap = '0;
            gap_vld   = '0;
            rel_cnt   = 0;
         end else begin
            if (rel_cnt < 2) begin
               for (int c = 0; c < 2; c++) begin
                  checks++;
                  if (tgt_ready[c] !== (rel_cnt == 1)) begin
                     errors++;
                     $display("FAIL ready_after_release ch%0d cycle %0d got %b want %b",
                              c, rel_cnt, tgt_ready[c], (rel_cnt == 1));
                  end
               end
               rel_cnt++;
            end

            for (int c = 0; c < 2; c++) begin
               if (tgt_valid[c] && tgt_ready[c]) begin
                  checks++;
                  if (acc_q.size() == 0 || int'(acc_q[0].ch) != c) begin
                     errors++;
                     $display("FAIL unexpected_transfer ch%0d got tgt=%0d want no transfer", c, tgt[c]);
                  end else begin
                     a = acc_q.pop_front();
                     if (a.tgt !== tgt[c]) begin
                        errors++;
                        $display("FAIL transfer_tgt ch%0d got %0d want %0d", c, tgt[c], a.tgt);
                     end
                  end
               end

               // Phase 0 cycle: its out sample closes the previous period.
               if (prev_wrap[c]) begin
                  h     = hi[c] + int'(pwm[c]);
                  hi[c] = 0;
                  if (win_q.size() > 0 && int'(win_q[0].ch) == c) begin
                     r = win_q.pop_front();
                     checks++;
                     if (h != int'(r.hi) || duty[c] !== r.duty || busy[c] !== r.busy ||
                         tgt_ready[c] !== r.rdy) begin
                        errors++;
                        $display("FAIL period_record ch%0d got hi=%0d duty=%0d busy=%b rdy=%b want hi=%0d duty=%0d busy=%b rdy=%b",
                                 c, h, duty[c], busy[c], tgt_ready[c], r.hi, r.duty, r.busy, r.rdy);
                     end
                  end
               end else begin
                  hi[c] = hi[c] + int'(pwm[c]);
               end

               gap[c]++;
               if (wrap[c]) begin
                  if (gap_vld[c]) begin
                     checks++;
                     if (gap[c] != PER) begin
                        errors++;
                        $display("FAIL wrap_spacing ch%0d got %0d want %0d", c, gap[c], PER);
                     end
                  end
                  gap_vld[c] = 1'b1;
                  gap[c]     = 0;
               end
               prev_wrap[c] = wrap[c];
            end
         end

         if (done) begin
            checks++;
            if (win_q.size() != 0) begin
               errors++;
               $display("FAIL records_left got %0d want 0", win_q.size());
            end
            checks++;
            if (acc_q.size() != 0) begin
               errors++;
               $display("FAIL transfers_left got %0d want 0", acc_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Slew-limited duty-cycle controller for a single PWM channel. It accepts target duty values over a valid/ready handshake and steps the applied duty one LSB at a time toward the target, once every `step_per` PWM periods. Duty changes take effect only on period boundaries, so no output period is ever truncated or glitched. It owns the phase counter and the compare stage, and drives the pin directly, e.g. for LED fading or soft-start of loads.

## Interface
- `period`, 8: PWM period in `clk` cycles, ≥2; duty width `W = $clog2(period)`, duty range 0..period-1
- `step_per`, 1: PWM periods per ramp step, ≥1
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `tgt`  in  W  requested target duty
- `tgt_valid`  in  1  target offered
- `tgt_ready`  out  1  controller accepts a target this cycle
- `duty`  out  W  currently applied duty
- `busy`  out  1  ramp in progress
- `wrap`  out  1  single-cycle pulse on the last cycle of each PWM period
- `out`  out  1  PWM output

## Operation
- Reset values: phase=0, duty=0, step count=0, state IDLE, `tgt_ready`=0, `busy`=0, `wrap`=0, `out`=0.
- `tgt_ready` rises on the first clock after `rst` deasserts, then equals (state==IDLE). It is registered.
- Phase counter runs 0..period-1 and wraps. `wrap`=1 while phase==period-1.
- `out` is registered: `out` at t+1 = (phase_t < duty_t). Duty 0 gives constant low; duty period-1 gives one low cycle per period.
- Transfer occurs when `tgt_valid & tgt_ready`. The controller latches `tgt` as target and clears the step count.
  - If the target equals `duty`, the state stays IDLE.
  - Otherwise the state goes to RAMP, `busy`=1, `tgt_ready`=0.
- States and transitions:
  - IDLE: waits for a transfer.
  - RAMP: on each `wrap`, step count increments. When the count reaches step_per-1, the count clears and `duty` moves ±1 toward the target in that same `wrap` cycle. When the new duty equals the target, the state returns to IDLE.
- Width rules: duty and target are unsigned W bits, and all values are legal. Step arithmetic never over- or underflows because it stops at the target.
- `tgt_valid` while busy is ignored; the source must hold it until `tgt_ready`.
- `rst` mid-ramp immediately forces all reset values, and the ramp is abandoned.

## Timing
- Transfer at edge t: `busy`=1 and `tgt_ready`=0 from t+1.
- The first step occurs on the step_per-th `wrap` after the transfer. The first `wrap` may close a partial period.
- The new duty is visible on `duty` from the cycle after `wrap`, i.e. phase 0. It is reflected on `out` from phase 0's registered output, one cycle later.
- Ramp of distance D takes D·step_per wraps. `busy` falls, and `tgt_ready` rises, the cycle after the final step's `wrap`.
- Transfer and `wrap` in the same cycle: the wrap is not counted for the new ramp.

## Structure
- No shared package is needed. Local parameter `W` is derived in-module.
- One natural sub-module: `pwm_ramp_core`, holding the phase counter and registered compare (`phase`, `duty` → `out`, `wrap`).
- The FSM, step counter and handshake stay in the top module.

## Test plan
- Reset with `period`=8, `step_per`=1, `tgt`=3 offered after release: accepted on the first ready cycle; duty goes 0→1→2→3 on three consecutive wraps; `busy` drops after the third; high cycles per period are 0,1,2,3.
- Assert `rst` mid-ramp, then release: `out`, `duty`, `busy` and `tgt_ready` are all 0 during reset; `tgt_ready`=1 one clock after release.
- Offer `tgt`=6, hold `tgt_valid` with new values during the ramp: no transfer occurs until `busy` falls; the ramp ends exactly at 6.
- Offer `tgt` equal to the current duty: it is accepted; `busy` stays 0; `tgt_ready` stays 1.
- `step_per`=2, duty 3, `tgt`=0: duty steps on every second wrap; three steps complete in 6 wraps; `out` stays low for the full period at duty 0.
- Duty 7 at `period`=8: `out` high 7 cycles, low 1 cycle per period; `wrap` pulses every 8 clocks.
